// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared definitions for the pipeline control unit: stage indices, redirect constants,
// mul/div handshake state encoding and the load-use hazard test.
package pipe_ctrl_unit_pkg;

    localparam int NUM_STAGES_DEF = 5;

    localparam int STAGE_IF  = 0;
    localparam int STAGE_ID  = 1;
    localparam int STAGE_EX  = 2;
    localparam int STAGE_MEM = 3;
    localparam int STAGE_WB  = 4;

    localparam logic [31:0] EXC_VEC_DEF   = 32'hBFC00380;
    localparam logic [31:0] ERET_CODE_DEF = 32'h0000000E;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // Register $zero never carries a real dependency, so it can never interlock.
    function automatic logic load_use_hazard(
        input logic       ex_rmem,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt
    );
        return ex_rmem && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// Bundle between the pipeline control unit and the datapath / mul-div unit.
// master = datapath side, slave = control unit side.
interface pipe_ctrl_unit_if #(
    parameter int NUM_STAGES = 5
);

    logic [NUM_STAGES-1:0] stall_req;
    logic [4:0]            id_rs;
    logic [4:0]            id_rt;
    logic [4:0]            ex_rt;
    logic                  ex_rmem;
    logic                  md_op;
    logic                  md_done;
    logic                  md_start;
    logic                  md_abort;
    logic                  exc_valid;
    logic [31:0]           exc_code;
    logic [31:0]           cp0_epc;
    logic [NUM_STAGES-1:0] stall;
    logic [NUM_STAGES-1:0] flush;
    logic                  redirect_valid;
    logic [31:0]           redirect_pc;
    logic [31:0]           stall_cycles;

    modport master (
        output stall_req, id_rs, id_rt, ex_rt, ex_rmem,
        output md_op, md_done, exc_valid, exc_code, cp0_epc,
        input  md_start, md_abort, stall, flush,
        input  redirect_valid, redirect_pc, stall_cycles
    );

    modport slave (
        input  stall_req, id_rs, id_rt, ex_rt, ex_rmem,
        input  md_op, md_done, exc_valid, exc_code, cp0_epc,
        output md_start, md_abort, stall, flush,
        output redirect_valid, redirect_pc, stall_cycles
    );

endinterface

// File: rtl/pipe_ctrl_unit_md_handshake.sv
// Start/busy/done handshake with the multi-cycle mul/div unit: one start pulse per
// instruction, EX held while the unit works, abort pulse if an exception kills the op.
module pipe_ctrl_unit_md_handshake
    import pipe_ctrl_unit_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic md_op,
    input  logic md_done,
    input  logic exc_valid,
    output logic md_start,
    output logic md_abort,
    output logic md_busy
);

    md_state_e state_q;
    md_state_e state_d;
    logic      start_c;
    logic      abort_c;

    always_comb begin
        state_d = state_q;
        start_c = 1'b0;
        abort_c = 1'b0;
        md_busy = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (md_op && !exc_valid) begin
                    start_c = 1'b1;
                    md_busy = 1'b1;
                    state_d = MD_BUSY;
                end
            end
            MD_BUSY: begin
                md_busy = 1'b1;
                if (exc_valid) begin
                    abort_c = 1'b1;
                    state_d = MD_IDLE;
                end else if (md_done) begin
                    state_d = MD_DONE;
                end
            end
            // The op leaves EX this cycle; md_op is still high but must not restart the unit.
            MD_DONE: begin
                state_d = MD_IDLE;
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase
    end

    assign md_start = start_c & resetn;
    assign md_abort = abort_c & resetn;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control for the N-stage MIPS core: per-stage stall/flush, load-use interlock,
// mul/div handshake and exception/ERET redirect with a pending hold while IF is stalled.
module pipe_ctrl_unit
    import pipe_ctrl_unit_pkg::*;
#(
    parameter int          NUM_STAGES = NUM_STAGES_DEF,
    parameter int          LU_STAGE   = STAGE_ID,
    parameter int          MD_STAGE   = STAGE_EX,
    parameter logic [31:0] EXC_VEC    = EXC_VEC_DEF,
    parameter logic [31:0] ERET_CODE  = ERET_CODE_DEF
) (
    input  logic            clk,
    input  logic            resetn,
    pipe_ctrl_unit_if.slave bus
);

    logic                  lu;
    logic                  md_busy;
    logic                  md_start;
    logic                  md_abort;
    logic [NUM_STAGES-1:0] req_vec;
    logic [NUM_STAGES-1:0] stall_raw;
    logic [NUM_STAGES-1:0] flush_vec;
    logic [NUM_STAGES-1:0] stall_vec;
    logic [31:0]           target;
    logic                  pend_q;
    logic                  pend_d;
    logic [31:0]           pc_q;
    logic [31:0]           pc_d;
    logic [31:0]           stall_cycles_q;
    logic [31:0]           stall_cycles_d;

    pipe_ctrl_unit_md_handshake u_md_handshake (
        .clk       (clk),
        .resetn    (resetn),
        .md_op     (bus.md_op),
        .md_done   (bus.md_done),
        .exc_valid (bus.exc_valid),
        .md_start  (md_start),
        .md_abort  (md_abort),
        .md_busy   (md_busy)
    );

    assign lu = load_use_hazard(bus.ex_rmem, bus.ex_rt, bus.id_rs, bus.id_rt);

    always_comb begin
        req_vec           = bus.stall_req;
        req_vec[LU_STAGE] = req_vec[LU_STAGE] | lu;
        req_vec[MD_STAGE] = req_vec[MD_STAGE] | md_busy;
    end

    // A stalled stage holds every younger stage; the first stage past the stall gets a bubble.
    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        assign stall_raw[g] = |req_vec[NUM_STAGES-1:g];
        if (g == 0) begin : g_first
            assign flush_vec[g] = bus.exc_valid;
        end else begin : g_rest
            assign flush_vec[g] = bus.exc_valid | (stall_raw[g-1] & ~stall_raw[g]);
        end
    end

    assign stall_vec = stall_raw & ~flush_vec;

    assign target = (bus.exc_code == ERET_CODE) ? bus.cp0_epc : EXC_VEC;

    always_comb begin
        pend_d = pend_q;
        pc_d   = pc_q;
        if (bus.exc_valid && bus.stall_req[STAGE_IF]) begin
            pend_d = 1'b1;
            pc_d   = target;
        end else if (pend_q && !bus.stall_req[STAGE_IF]) begin
            pend_d = 1'b0;
        end
        stall_cycles_d = stall_cycles_q + {31'd0, stall_vec[STAGE_IF]};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_q         <= 1'b0;
            pc_q           <= 32'd0;
            stall_cycles_q <= 32'd0;
        end else begin
            pend_q         <= pend_d;
            pc_q           <= pc_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // A fresh exception outranks the one still waiting for IF.
    assign bus.redirect_valid = bus.exc_valid | pend_q;
    assign bus.redirect_pc    = (pend_q && !bus.exc_valid) ? pc_q : target;
    assign bus.stall          = stall_vec;
    assign bus.flush          = flush_vec;
    assign bus.md_start       = md_start;
    assign bus.md_abort       = md_abort;
    assign bus.stall_cycles   = stall_cycles_q;

endmodule
